// File: rtl/lsu_mem_ctrl.sv
// Load/store controller between the core request port and a word-addressed data memory.
// Word-crossing accesses are split into two back-to-back memory beats.
module lsu_mem_ctrl #(
   parameter bit ALLOW_MISALIGNED = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic        rsp_err,
   output logic [31:0] rsp_rdata,
   output logic        cs,
   output logic        wr,
   output logic [3:0]  mask,
   output logic [31:0] addr,
   output logic [31:0] data_wr,
   input  logic [31:0] data_rd
);

   typedef enum logic [1:0] {IDLE, ACC1, ACC2, RESP} state_e;

   state_e      state_q, state_d;
   logic        we_q, we_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [1:0]  off_q, off_d;
   logic [29:0] word_q, word_d;
   logic [31:0] wdata_q, wdata_d;
   logic        cross_q, cross_d;
   logic        err_q, err_d;
   logic [31:0] rd1_q, rd1_d;
   logic [31:0] rdata_q, rdata_d;

   logic        accept;
   logic [2:0]  req_size;
   logic        req_cross;
   logic        req_illegal;
   logic [2:0]  cur_size;
   logic [7:0]  lane;
   logic [63:0] store_full;
   logic [31:0] load_w1;
   logic [31:0] load_w2;
   logic [31:0] load_val;

   function automatic logic [2:0] size_of(input logic [2:0] f3);
      case (f3[1:0])
         2'b00:   return 3'd1;
         2'b01:   return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

   function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] r);
      case (f3)
         3'b000:  return {{24{r[7]}}, r[7:0]};
         3'b001:  return {{16{r[15]}}, r[15:0]};
         3'b100:  return {24'h0, r[7:0]};
         3'b101:  return {16'h0, r[15:0]};
         default: return r;
      endcase
   endfunction

   always_comb begin : decode
      accept    = req_valid && (state_q == IDLE);
      req_size  = size_of(req_funct3);
      req_cross = ({1'b0, req_addr[1:0]} + req_size) > 3'd4;
      req_illegal = 1'b0;
      if (req_funct3 == 3'b011 || req_funct3 == 3'b110 || req_funct3 == 3'b111)
         req_illegal = 1'b1;
      if (req_we && req_funct3[2])
         req_illegal = 1'b1;
      if (!ALLOW_MISALIGNED) begin
         if ((req_size == 3'd2 && req_addr[0]) || (req_size == 3'd4 && req_addr[1:0] != 2'b00))
            req_illegal = 1'b1;
      end
   end

   // Lane mask and store data span two words; the high half belongs to the second beat.
   always_comb begin : lanes
      cur_size   = size_of(funct3_q);
      lane       = ((8'h01 << cur_size) - 8'h01) << off_q;
      store_full = {32'h0, wdata_q} << {off_q, 3'b000};
      load_w1    = (state_q == ACC1) ? data_rd : rd1_q;
      load_w2    = (state_q == ACC2) ? data_rd : 32'h0;
      load_val   = extend(funct3_q, 32'({load_w2, load_w1} >> {off_q, 3'b000}));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         we_q     <= 1'b0;
         funct3_q <= 3'b000;
         off_q    <= 2'b00;
         word_q   <= 30'h0;
         wdata_q  <= 32'h0;
         cross_q  <= 1'b0;
         err_q    <= 1'b0;
         rd1_q    <= 32'h0;
         rdata_q  <= 32'h0;
      end else begin
         state_q  <= state_d;
         we_q     <= we_d;
         funct3_q <= funct3_d;
         off_q    <= off_d;
         word_q   <= word_d;
         wdata_q  <= wdata_d;
         cross_q  <= cross_d;
         err_q    <= err_d;
         rd1_q    <= rd1_d;
         rdata_q  <= rdata_d;
      end
   end

   always_comb begin : next_state
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = req_illegal ? RESP : ACC1;
         ACC1:    state_d = cross_q ? ACC2 : RESP;
         ACC2:    state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin : datapath
      we_d     = we_q;
      funct3_d = funct3_q;
      off_d    = off_q;
      word_d   = word_q;
      wdata_d  = wdata_q;
      cross_d  = cross_q;
      err_d    = err_q;
      rd1_d    = rd1_q;
      rdata_d  = rdata_q;
      if (accept) begin
         we_d     = req_we;
         funct3_d = req_funct3;
         off_d    = req_addr[1:0];
         word_d   = req_addr[31:2];
         wdata_d  = req_wdata;
         cross_d  = req_cross;
         err_d    = req_illegal;
         if (req_illegal)
            rdata_d = 32'h0;
      end
      // The response data is committed on the last memory beat of the access.
      if (state_q == ACC1) begin
         rd1_d = data_rd;
         if (!cross_q)
            rdata_d = we_q ? 32'h0 : load_val;
      end
      if (state_q == ACC2)
         rdata_d = we_q ? 32'h0 : load_val;
   end

   always_comb begin : outputs
      req_ready = (state_q == IDLE) && !rst;
      cs        = 1'b1;
      wr        = 1'b1;
      mask      = 4'h0;
      addr      = 32'h0;
      data_wr   = 32'h0;
      rsp_valid = 1'b0;
      rsp_err   = 1'b0;
      rsp_rdata = rst ? 32'h0 : rdata_q;
      if (!rst) begin
         case (state_q)
            ACC1: begin
               cs      = 1'b0;
               wr      = ~we_q;
               mask    = lane[3:0];
               addr    = {2'b00, word_q};
               data_wr = store_full[31:0];
            end
            ACC2: begin
               cs      = 1'b0;
               wr      = ~we_q;
               mask    = lane[7:4];
               addr    = {2'b00, word_q + 30'd1};
               data_wr = store_full[63:32];
            end
            RESP: begin
               rsp_valid = 1'b1;
               rsp_err   = err_q;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/lsu_mem_ctrl.md
# lsu_mem_ctrl

Load/store controller between the core's load/store request port and the word-addressed data memory (active-low `cs`, `wr`=0 write / `wr`=1 read, 4-bit byte mask, asynchronous read, write on falling clock edge). It decodes RV32 load/store size from `funct3` and converts byte addresses to word indices. It produces byte-lane masks and lane-aligned store data, and sign/zero-extends load data. Accesses that cross a word boundary are split into two sequential memory accesses.

## Interface
- `ALLOW_MISALIGNED`, default 1: 1 = split word-crossing accesses; 0 = any non-naturally-aligned access returns an error with no memory access.

- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `req_valid`  in  1  request present
- `req_ready`  out  1  controller can accept; high only in IDLE
- `req_we`  in  1  1 = store, 0 = load
- `req_funct3`  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU (loads only)
- `req_addr`  in  32  byte address
- `req_wdata`  in  32  store data, right-justified
- `rsp_valid`  out  1  one-cycle completion pulse, no back-pressure
- `rsp_err`  out  1  illegal funct3 / disallowed misalignment; qualified by `rsp_valid`
- `rsp_rdata`  out  32  extended load data; 0 for stores and errors; held between responses
- `cs`  out  1  memory select, active-low
- `wr`  out  1  0 = write, 1 = read
- `mask`  out  4  byte-lane enables, driven for reads too
- `addr`  out  32  word index, `{2'b0, word[29:0]}`
- `data_wr`  out  32  lane-aligned store data
- `data_rd`  in  32  memory read data, combinational

## Operation
- States: IDLE, ACC1, ACC2, RESP.
- IDLE: `req_valid & req_ready` captures the request.
  - Legal request → ACC1.
  - Illegal request → RESP with err = 1.
- Size is n = 1/2/4 bytes and offset o = `addr[1:0]`. The access is crossing when o + n > 4.
- Illegal cases:
  - funct3 ∉ {000, 001, 010, 100, 101}.
  - Store with funct3 100 or 101.
  - ALLOW_MISALIGNED = 0 and o mod n ≠ 0.
- ACC1 → ACC2 if crossing, else → RESP. ACC2 → RESP. RESP → IDLE.
- Lane mask L = ((1<<n) − 1) << o, 8 bits wide.
  - ACC1 uses word index W = `addr[31:2]`, `mask` = L[3:0].
  - ACC2 uses index W + 1 modulo 2^30 (0x3FFFFFFF wraps to 0), `mask` = L[7:4].
- Store data S = `{32'b0, wdata} << 8·o`. ACC1 `data_wr` = S[31:0]; ACC2 `data_wr` = S[63:32].
- Loads:
  - `data_rd` is captured at the end of each ACC cycle.
  - Result is R = `{word2, word1} >> 8·o`, with word2 = 0 when the access is not crossing.
  - R is truncated to n bytes, then sign-extended (B/H) or zero-extended (BU/HU/W).
  - The result is registered into `rsp_rdata` at the final ACC edge.
- `cs` = 0 only in ACC1/ACC2. `wr` = ~`req_we` in ACC states and 1 elsewhere.
- Outside ACC states: `mask` = 0, `addr` = 0, `data_wr` = 0.

## Timing
- Reset values: state IDLE, `req_ready`=1 after reset release, `rsp_valid`=0, `rsp_err`=0, `rsp_rdata`=0, `cs`=1, `wr`=1, `mask`=0, `addr`=0, `data_wr`=0.
- `req_ready` reads 0 while `rst` is high.
- `cs` is forced to 1 combinationally while `rst`=1. Reset asserted in ACC1 therefore causes no write.
- Reset asserted in ACC2 aborts the second word; the first word stays written.
- Cycle counts relative to the acceptance cycle 0:
  - Aligned access: ACC1 in cycle 1, `rsp_valid` in cycle 2.
  - Crossing access: `rsp_valid` in cycle 3.
  - Error: `rsp_valid` in cycle 1.
- Next acceptance is possible in cycle 3 for aligned accesses and cycle 4 for crossing accesses.
- Requests presented while `req_ready`=0 are ignored (not queued). The requester holds them.
- A store's memory write occurs at the falling edge inside its ACC cycle. A load issued immediately after sees the stored data.

## Test plan
- SW 0xDEADBEEF @0x10:
  - Cycle 1 shows `cs`=0, `wr`=0, `addr`=4, `mask`=1111, `data_wr`=0xDEADBEEF.
  - Cycle 2 shows `rsp_valid`=1, `rsp_err`=0.
  - A following LW @0x10 returns 0xDEADBEEF.
- SB 0xA5 @0x13:
  - Cycle 1 shows `mask`=1000, `data_wr`=0xA5000000.
  - LB @0x13 returns 0xFFFFFFA5; LBU @0x13 returns 0x000000A5.
- SW 0x11223344 @0x1E:
  - ACC1 shows `addr`=7, `mask`=1100, `data_wr`=0x33440000.
  - ACC2 shows `addr`=8, `mask`=0011, `data_wr`=0x00001122.
  - `rsp_valid` rises in cycle 3.
  - LW @0x1E returns 0x11223344.
- Memory word 8 = 0x7F000000, word 9 = 0x000000FF:
  - LH @0x23 returns 0xFFFFFF7F; LHU @0x23 returns 0x0000FF7F.
  - SW @0xFFFFFFFE: ACC2 `addr` = 0, `mask` = 0011.
- Load with funct3=011:
  - `rsp_valid`=1 and `rsp_err`=1 in cycle 1; `cs` stays 1 throughout.
  - SB with funct3=100 gives the same error.
  - With ALLOW_MISALIGNED=0, LW @0x02 gives `rsp_err`=1 and no access.
- `rst`=1 during ACC1 of SW 0xCAFEF00D @0x40:
  - `cs`=1 that cycle and word 16 is unchanged.
  - All outputs hold reset values.
  - `req_ready`=1 the cycle after `rst` drops.
